// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_controller request port between two masters.
// Optional macro MEM_ARB_TIMEOUT_EN adds a read timeout (rdata 32'hDEADDEAD, sticky rd_err).
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WR_GAP         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_done,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_done,
    output logic                  mc_wr_req,
    output logic                  mc_rd_req,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [DATA_WIDTH-1:0] mc_wdata,
    input  logic [DATA_WIDTH-1:0] mc_rdata,
    input  logic                  mc_rd_valid,
    output logic                  grant,
    output logic                  busy,
    output logic                  rd_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_HOLD = 2'd2;

    localparam logic [3:0] WR_LOAD = 4'(WR_GAP - 1);

    if (WR_GAP < 1 || WR_GAP > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: WR_GAP must be 1..15 and TIMEOUT_CYCLES at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  mc_rd_req_q, mc_rd_req_d;
    logic                  mc_wr_req_q, mc_wr_req_d;
    logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
    logic [DATA_WIDTH-1:0] mc_wdata_q, mc_wdata_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m0_done_q, m0_done_d;
    logic                  m1_done_q, m1_done_d;
    logic [3:0]            wr_cnt_q, wr_cnt_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rd_err_q, rd_err_d;
`endif

    logic                  m0_elig, m1_elig, pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  rd_fin;
    logic [DATA_WIDTH-1:0] rd_val;

    // A request still high during its own done pulse is not a new request.
    assign m0_elig   = m0_req & ~m0_done_q;
    assign m1_elig   = m1_req & ~m1_done_q;
    assign pick      = (m0_elig & m1_elig) ? ~last_grant_q : m1_elig;
    assign sel_we    = pick ? m1_we    : m0_we;
    assign sel_addr  = pick ? m1_addr  : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;

    always_comb begin
        // NOTE: every _d signal gets its default first, so no path through the case infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        mc_rd_req_d  = 1'b0;
        mc_wr_req_d  = 1'b0;
        mc_addr_d    = mc_addr_q;
        mc_wdata_d   = mc_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_done_d    = 1'b0;
        m1_done_d    = 1'b0;
        wr_cnt_d     = wr_cnt_q;
        rd_fin       = 1'b0;
        rd_val       = mc_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        rd_err_d     = rd_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (m0_elig | m1_elig) begin
                    last_grant_d = pick;
                    grant_d      = pick;
                    busy_d       = 1'b1;
                    mc_addr_d    = sel_addr;
                    mc_wdata_d   = sel_wdata;
                    if (sel_we) begin
                        state_d     = ST_WR_HOLD;
                        mc_wr_req_d = 1'b1;
                        wr_cnt_d    = WR_LOAD;
                    end else begin
                        state_d     = ST_RD_WAIT;
                        mc_rd_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end

            ST_RD_WAIT: begin
                if (mc_rd_valid) begin
                    rd_fin = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rd_fin   = 1'b1;
                    rd_val   = DATA_WIDTH'(32'hDEADDEAD);
                    rd_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end

            ST_WR_HOLD: begin
                if (wr_cnt_q == 4'd0) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    m0_done_d = ~grant_q;
                    m1_done_d = grant_q;
                end else begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (rd_fin) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (grant_q) begin
                m1_rdata_d = rd_val;
                m1_done_d  = 1'b1;
            end else begin
                m0_rdata_d = rd_val;
                m0_done_d  = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments, so every flop samples the pre-edge _d values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            mc_rd_req_q  <= 1'b0;
            mc_wr_req_q  <= 1'b0;
            mc_addr_q    <= '0;
            mc_wdata_q   <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            wr_cnt_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            rd_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            mc_rd_req_q  <= mc_rd_req_d;
            mc_wr_req_q  <= mc_wr_req_d;
            mc_addr_q    <= mc_addr_d;
            mc_wdata_q   <= mc_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_done_q    <= m0_done_d;
            m1_done_q    <= m1_done_d;
            wr_cnt_q     <= wr_cnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            rd_err_q     <= rd_err_d;
`endif
        end
    end

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign mc_rd_req = mc_rd_req_q;
    assign mc_wr_req = mc_wr_req_q;
    assign mc_addr   = mc_addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign rd_err    = rd_err_q;
`else
    assign rd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected strobes and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int WR_GAP  = 2;
    localparam int TIMEOUT = 8;

    logic          clk;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_done, m1_done;
    logic          mc_wr_req, mc_rd_req;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wdata;
    logic [DW-1:0] mc_rdata;
    logic          mc_rd_valid;
    logic          grant, busy, rd_err;

    mem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .WR_GAP        (WR_GAP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_done    (m0_done),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_done    (m1_done),
        .mc_wr_req  (mc_wr_req),
        .mc_rd_req  (mc_rd_req),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_rdata   (mc_rdata),
        .mc_rd_valid(mc_rd_valid),
        .grant      (grant),
        .busy       (busy),
        .rd_err     (rd_err)
    );

    typedef struct {
        bit            m;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
    } txn_t;

    txn_t          exp_mc[$];
    txn_t          exp_done[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            issue_cyc = 0;
    logic [DW-1:0] exp_rdata [2];
    logic [DW-1:0] mem [0:1023];
    bit            model_en = 1'b1;
    int            inject_cnt = 0;
    logic [DW-1:0] inject_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Memory model: answers a read one cycle after the strobe; also replays injected stray valids.
    initial begin
        bit            rd_pending = 1'b0;
        logic [AW-1:0] pend_addr  = '0;
        int            inject_seen = 0;
        mc_rd_valid = 1'b0;
        mc_rdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            mc_rd_valid = 1'b0;
            if (rd_pending) begin
                mc_rd_valid = 1'b1;
                mc_rdata    = mem[pend_addr];
            end else if (inject_cnt != inject_seen) begin
                inject_seen = inject_cnt;
                mc_rd_valid = 1'b1;
                mc_rdata    = inject_data;
            end
            rd_pending = model_en && (mc_rd_req === 1'b1);
            pend_addr  = mc_addr;
        end
    end

    // Monitor: pops the scoreboard on every downstream strobe and every done pulse.
    initial begin
        txn_t e;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                exp_rdata[0] = '0;
                exp_rdata[1] = '0;
            end else begin
                if (mc_rd_req === 1'b1 || mc_wr_req === 1'b1) begin
                    check("strobe_onehot", 64'(mc_rd_req & mc_wr_req), 64'd0);
                    if (exp_mc.size() == 0) begin
                        check("spurious_strobe", 64'({mc_rd_req, mc_wr_req}), 64'd0);
                    end else begin
                        e = exp_mc.pop_front();
                        check("mc_op_is_write", 64'(mc_wr_req), 64'(e.we));
                        check("mc_addr", 64'(mc_addr), 64'(e.addr));
                        if (e.we) check("mc_wdata", 64'(mc_wdata), 64'(e.data));
                        check("grant_at_issue", 64'(grant), 64'(e.m));
                        check("busy_at_issue", 64'(busy), 64'd1);
                        issue_cyc = cyc;
                    end
                end
                if (m0_done === 1'b1 || m1_done === 1'b1) begin
                    check("done_onehot", 64'(m0_done & m1_done), 64'd0);
                    if (exp_done.size() == 0) begin
                        check("spurious_done", 64'({m1_done, m0_done}), 64'd0);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_master", 64'(m1_done), 64'(e.m));
                        check("done_latency", 64'(cyc - issue_cyc), 64'(e.lat));
                        check("grant_at_done", 64'(grant), 64'(e.m));
                        check("busy_at_done", 64'(busy), 64'd0);
                        if (!e.we) exp_rdata[e.m] = e.data;
                        check("m0_rdata", 64'(m0_rdata), 64'(exp_rdata[0]));
                        check("m1_rdata", 64'(m1_rdata), 64'(exp_rdata[1]));
                    end
                end
            end
        end
    end

    task automatic expect_txn(input bit m, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int lat);
        txn_t e;
        e.m = m; e.we = we; e.addr = a; e.data = d; e.lat = lat;
        exp_mc.push_back(e);
        exp_done.push_back(e);
    endtask

    task automatic set_master(input bit m, input logic req, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic clear_req(input bit m);
        if (m) m1_req = 1'b0;
        else   m0_req = 1'b0;
    endtask

    task automatic wait_done(input bit m);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m ? m1_done : m0_done) === 1'b1) return;
        end
        check(m ? "m1_done_timeout" : "m0_done_timeout", 64'(m ? m1_done : m0_done), 64'd1);
    endtask

    task automatic txn(input bit m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        set_master(m, 1'b1, we, a, d);
        wait_done(m);
        clear_req(m);
    endtask

    // Request held high across done pulses; only the address changes between reads.
    task automatic stream(input bit m, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2);
        logic [AW-1:0] addrs [3];
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_master(m, 1'b1, 1'b0, addrs[i], '0);
            wait_done(m);
        end
        clear_req(m);
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mc_rd_req === 1'b1 || mc_wr_req === 1'b1) return;
        end
        check("strobe_timeout", 64'({mc_rd_req, mc_wr_req}), 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_mc.size() == 0 && exp_done.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check({tag, "_strobes_left"}, 64'(exp_mc.size()), 64'd0);
        check({tag, "_dones_left"}, 64'(exp_done.size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, grant, mc_rd_req, mc_wr_req, m0_done, m1_done, rd_err}), 64'd0);
        check({tag, "_m0_rdata"}, 64'(m0_rdata), 64'd0);
        check({tag, "_m1_rdata"}, 64'(m1_rdata), 64'd0);
        check({tag, "_mc_bus"}, {22'd0, mc_addr, mc_wdata}, 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero(tag);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_master(1'b0, 1'b0, 1'b0, '0, '0);
        set_master(1'b1, 1'b0, 1'b0, '0, '0);
        mem[10] = 32'hCAFEBABE;
        mem[20] = 32'h0000_1111;
        mem[21] = 32'h2222_0000;
        mem[30] = 32'h3000_0030;
        mem[31] = 32'h3000_0031;
        mem[32] = 32'h3000_0032;
        mem[40] = 32'h4000_0040;
        mem[41] = 32'h4000_0041;
        mem[42] = 32'h4000_0042;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Master 0 write; a stray mc_rd_valid during WR_HOLD must be ignored.
        expect_txn(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, WR_GAP);
        fork
            txn(1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
            begin
                wait_strobe();
                inject_data = 32'h1234_5678;
                inject_cnt++;
            end
        join
        drain("write_m0");

        expect_txn(1'b1, 1'b0, 10'd10, 32'hCAFEBABE, 2);
        txn(1'b1, 1'b0, 10'd10, '0);
        drain("read_m1");

        // Simultaneous reads straight out of reset: master 0 wins the first tie.
        pulse_reset("reset2");
        expect_txn(1'b0, 1'b0, 10'd20, 32'h0000_1111, 2);
        expect_txn(1'b1, 1'b0, 10'd21, 32'h2222_0000, 2);
        fork
            txn(1'b0, 1'b0, 10'd20, '0);
            txn(1'b1, 1'b0, 10'd21, '0);
        join
        drain("tie");

        // Continuous requests from both masters: strict 0,1,0,1,0,1.
        expect_txn(1'b0, 1'b0, 10'd30, 32'h3000_0030, 2);
        expect_txn(1'b1, 1'b0, 10'd40, 32'h4000_0040, 2);
        expect_txn(1'b0, 1'b0, 10'd31, 32'h3000_0031, 2);
        expect_txn(1'b1, 1'b0, 10'd41, 32'h4000_0041, 2);
        expect_txn(1'b0, 1'b0, 10'd32, 32'h3000_0032, 2);
        expect_txn(1'b1, 1'b0, 10'd42, 32'h4000_0042, 2);
        fork
            stream(1'b0, 10'd30, 10'd31, 10'd32);
            stream(1'b1, 10'd40, 10'd41, 10'd42);
        join
        drain("stream");

        // Reset while in RD_WAIT, then a late mc_rd_valid in IDLE.
        model_en = 1'b0;
        begin
            txn_t e;
            e.m = 1'b0; e.we = 1'b0; e.addr = 10'd50; e.data = '0; e.lat = 0;
            exp_mc.push_back(e);
        end
        @(negedge clk);
        set_master(1'b0, 1'b1, 1'b0, 10'd50, '0);
        wait_strobe();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m0_req = 1'b0;
        #1;
        check_zero("mid_read_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        inject_data = 32'hBAD0_BAD0;
        inject_cnt++;
        repeat (4) @(negedge clk);
        check("busy_after_late_valid", 64'(busy), 64'd0);
        check("m0_rdata_after_late_valid", 64'(m0_rdata), 64'd0);
        model_en = 1'b1;
        expect_txn(1'b0, 1'b0, 10'd10, 32'hCAFEBABE, 2);
        txn(1'b0, 1'b0, 10'd10, '0);
        drain("after_reset");

`ifdef MEM_ARB_TIMEOUT_EN
        model_en = 1'b0;
        expect_txn(1'b1, 1'b0, 10'd60, 32'hDEADDEAD, TIMEOUT);
        txn(1'b1, 1'b0, 10'd60, '0);
        drain("timeout");
        model_en = 1'b1;
        expect_txn(1'b0, 1'b0, 10'd20, 32'h0000_1111, 2);
        txn(1'b0, 1'b0, 10'd20, '0);
        drain("after_timeout");
        check("rd_err_sticky", 64'(rd_err), 64'd1);
`else
        check("rd_err_tied_low", 64'(rd_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter in front of the CPU-side request port of mem_controller.
- Shares one controller between master 0 (CPU) and master 1 (DMA/peripheral) using round-robin selection.
- Serialises traffic: only one transaction is outstanding downstream at any time.
- Routes read data and completion strobes back to the master that was granted.

Parameters:
- ADDR_WIDTH, 10, address width; matches mem_controller.
- DATA_WIDTH, 32, data width.
- WR_GAP, 2, cycles held in WR_HOLD after a write is issued, before done; legal range 1..15.
- TIMEOUT_CYCLES, 64, read timeout limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held until m0_done.
- m0_we  in  1  1 = write, 0 = read; stable while m0_req is high.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data; valid while m0_done is high.
- m0_done  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done: same as master 0, for master 1.
- mc_wr_req  out  1  one-cycle write strobe to the controller.
- mc_rd_req  out  1  one-cycle read strobe to the controller.
- mc_addr  out  ADDR_WIDTH  controller address.
- mc_wdata  out  DATA_WIDTH  controller write data.
- mc_rdata  in  DATA_WIDTH  controller read data.
- mc_rd_valid  in  1  controller read data valid.
- grant  out  1  index of the master currently owning the controller.
- busy  out  1  high in any state other than IDLE.
- rd_err  out  1  sticky timeout flag; constant 0 when MEM_ARB_TIMEOUT_EN is not defined.

Behaviour:
- Reset (reset = 0): all outputs go to 0, state = IDLE, last_grant = 1 so master 0 wins the first tie, and the counter clears. Outputs are registered.
- Eligibility: a master is eligible in IDLE when mN_req = 1 and mN_done = 0 that cycle. This masks a request that is still high in the cycle its done pulse is out.
- Arbitration: with one eligible master, grant it. With both eligible, grant the master not equal to last_grant. last_grant updates when a grant is made.
- States and transitions:
  - IDLE to RD_WAIT (read grant) or WR_HOLD (write grant). On the next edge, drive the selected master's address and data onto mc_addr/mc_wdata, pulse mc_rd_req or mc_wr_req for exactly 1 cycle, set grant, set busy = 1.
  - RD_WAIT: wait for mc_rd_valid = 1. On that edge, register mc_rdata into the granted master's rdata, pulse its done for 1 cycle, and return to IDLE. The other master's rdata holds its previous value.
  - WR_HOLD: a counter loads WR_GAP−1 when the write is issued and decrements each cycle. When it reaches 0, pulse done and return to IDLE.
- Latency:
  - Read done = one cycle after mc_rd_valid.
  - Write done = WR_GAP+1 cycles after the grant cycle.
  - Minimum gap between back-to-back grants: 1 IDLE cycle.
- mc_rd_valid arriving in IDLE or WR_HOLD is ignored, with no output change.
- mc_addr and mc_wdata hold their last values between transactions.
- A request that drops before done is undefined for the master. The arbiter still completes the transaction and pulses done.
- Reset mid-transaction: return immediately to IDLE with outputs at 0. A late mc_rd_valid after reset is ignored per the IDLE rule.
- Starvation bound: with both masters requesting continuously, grants alternate strictly 0,1,0,1,…

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - In RD_WAIT, a counter increments each cycle.
  - If it reaches TIMEOUT_CYCLES with no mc_rd_valid, pulse done to the granted master with rdata = 32'hDEADDEAD, set rd_err = 1 (sticky until reset), and return to IDLE.
  - A counter value below TIMEOUT_CYCLES never triggers the timeout.
- Undefined: RD_WAIT waits indefinitely, rd_err is tied to 0, and there is no timeout counter logic.

Test Plan:
- Master 0 writes addr 5, data 32'hDEADBEEF, WR_GAP = 2 → one mc_wr_req pulse with mc_addr = 5 and mc_wdata = DEADBEEF; m0_done 3 cycles after grant; m1_done stays 0.
- Master 1 reads addr 10, with the memory model returning 32'hCAFEBABE one cycle after mc_rd_req → m1_rdata = CAFEBABE with m1_done the following cycle; grant = 1 throughout.
- m0_req and m1_req (reads) asserted in the same cycle straight out of reset → master 0 served first, then master 1; exactly 2 mc_rd_req pulses.
- Both masters request continuously for 6 transactions → grant sequence 0,1,0,1,0,1 and no double grant to the requester whose done is high.
- reset pulsed low while in RD_WAIT, then mc_rd_valid arrives → all outputs 0, no done pulse, busy = 0, next request served normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, and the model never answering a read → done after 8 RD_WAIT cycles, rdata = DEADDEAD, rd_err = 1 and still 1 after a subsequent good read.
